// File: rtl/rop3_bist_if.sv
// Stimulus/result bus between the BIST sequencer and the two ROP3 units.
// The master side drives the vector; the slave side returns both results.
interface rop3_bist_if #(
  parameter int unsigned N = 6
);
  logic [N-1:0] P;
  logic [N-1:0] S;
  logic [N-1:0] D;
  logic [7:0]   Mode;
  logic [N-1:0] res_a;
  logic [N-1:0] res_b;

  modport master (output P, S, D, Mode, input res_a, res_b);
  modport slave  (input P, S, D, Mode, output res_a, res_b);
endinterface

// File: rtl/rop3_bist.sv
// Exhaustive {Mode,P,S,D} sweep into a golden and a tested ROP3 unit.
// Results are compared LAT cycles later; the first mismatch halts the run.
module rop3_bist #(
  parameter int unsigned N   = 6,
  parameter int unsigned LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              one_mode,
  input  logic [7:0]        mode_val,
  rop3_bist_if.master       rop,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [8+3*N-1:0]  fail_vec,
  output logic [N-1:0]      fail_a,
  output logic [N-1:0]      fail_b
);
  localparam int unsigned VW = 8 + 3 * N;
  localparam int unsigned SW = 3 * N;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_t;

  typedef struct packed {
    logic          valid;
    logic [VW-1:0] vec;
  } dl_t;

  state_t          state, state_nx;
  logic [VW-1:0]   cnt;
  logic            one_mode_q;
  logic [2:0]      dcnt;
  dl_t [LAT-1:0]   dl;

  logic start_ok_c, last_c, mismatch_c, drain_end_c, active_c;

  // The counter register is the stimulus register: {Mode,P,S,D} = cnt.
  assign rop.Mode = cnt[VW-1:SW];
  assign rop.P    = cnt[SW-1:2*N];
  assign rop.S    = cnt[2*N-1:N];
  assign rop.D    = cnt[N-1:0];

  assign active_c    = (state == RUN) || (state == DRAIN);
  assign start_ok_c  = start && ((state == IDLE) || (state == PASS) || (state == FAIL));
  assign last_c      = one_mode_q ? (&cnt[SW-1:0]) : (&cnt);
  assign drain_end_c = (dcnt == 3'(LAT - 1));
  assign mismatch_c  = active_c && dl[LAT-1].valid && (rop.res_a != rop.res_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, PASS, FAIL: if (start_ok_c) state_nx = RUN;
      RUN: begin
        if (mismatch_c)  state_nx = FAIL;
        else if (last_c) state_nx = DRAIN;
      end
      DRAIN: begin
        if (mismatch_c)       state_nx = FAIL;
        else if (drain_end_c) state_nx = PASS;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      one_mode_q <= 1'b0;
      dcnt       <= 3'd0;
      dl         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      busy <= (state_nx == RUN) || (state_nx == DRAIN);
      done <= (state_nx == PASS) || (state_nx == FAIL);
      pass <= (state_nx == PASS);

      // Vector 0 goes out on the start edge; the swept field never wraps.
      if (start_ok_c) begin
        one_mode_q <= one_mode;
        cnt        <= one_mode ? {mode_val, SW'(0)} : '0;
        fail_vec   <= '0;
        fail_a     <= '0;
        fail_b     <= '0;
      end else if ((state == RUN) && (state_nx == RUN)) begin
        cnt <= cnt + VW'(1);
      end

      dcnt <= (state == DRAIN) ? dcnt + 3'd1 : 3'd0;

      if (mismatch_c) begin
        fail_vec <= dl[LAT-1].vec;
        fail_a   <= rop.res_a;
        fail_b   <= rop.res_b;
      end

      // Only vectors shown during RUN are tagged valid; anything in flight is dropped on a halt.
      if (active_c && !mismatch_c) begin
        for (int i = int'(LAT) - 1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0].valid <= (state == RUN);
        dl[0].vec   <= cnt;
      end else begin
        dl <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rop3_bist.sv
// Bench for rop3_bist: behavioural ROP3 pair with selectable fault and latency,
// table of full runs plus hand-written reset/ignored-start sequences.
module tb_rop3_bist;
  localparam int unsigned N   = 2;
  localparam int unsigned LAT = 2;
  localparam int unsigned VW  = 8 + 3 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          one_mode;
  logic [7:0]    mode_val;
  logic          busy, done, pass;
  logic [VW-1:0] fail_vec;
  logic [N-1:0]  fail_a, fail_b;

  logic          inj_en;
  logic [VW-1:0] inj_vec;
  logic          b_slow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rop3_bist_if #(.N(N)) bus ();

  rop3_bist #(.N(N), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .one_mode (one_mode),
    .mode_val (mode_val),
    .rop      (bus),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_vec (fail_vec),
    .fail_a   (fail_a),
    .fail_b   (fail_b)
  );

  function automatic logic [N-1:0] rop3(input logic [7:0] m, input logic [N-1:0] p,
                                        input logic [N-1:0] s, input logic [N-1:0] d);
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i] = m[{p[i], s[i], d[i]}];
    return r;
  endfunction

  logic [VW-1:0] vec_c;
  logic [N-1:0]  pa0, pa1, pb0, pb1, pb2;
  assign vec_c = {bus.Mode, bus.P, bus.S, bus.D};

  // Two-stage golden unit; unit B optionally faulty and optionally one stage slower.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa0 <= '0; pa1 <= '0; pb0 <= '0; pb1 <= '0; pb2 <= '0;
    end else begin
      pa0 <= rop3(bus.Mode, bus.P, bus.S, bus.D);
      pa1 <= pa0;
      pb0 <= rop3(bus.Mode, bus.P, bus.S, bus.D) ^ ((inj_en && (vec_c == inj_vec)) ? N'(1) : N'(0));
      pb1 <= pb0;
      pb2 <= pb1;
    end
  end
  assign bus.res_a = pa1;
  assign bus.res_b = b_slow ? pb2 : pb1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    string         name;
    logic          do_rst;
    logic          om;
    logic [7:0]    mv;
    logic          inj;
    logic [VW-1:0] iv;
    logic          slow;
    int            exp_edges;
    int            exp_busy;
    logic          exp_pass;
    logic [VW-1:0] exp_fv;
    logic [N-1:0]  exp_fa;
    logic [N-1:0]  exp_fb;
    logic [VW-1:0] exp_hold;
  } run_t;

  run_t tbl[5];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_one(input run_t r);
    int edges;
    int busy_n;
    int mode_bad;
    if (r.do_rst) do_reset();
    inj_en   = r.inj;
    inj_vec  = r.iv;
    b_slow   = r.slow;
    @(negedge clk);
    one_mode = r.om;
    mode_val = r.mv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    one_mode = 1'b0;
    mode_val = 8'h00;
    edges    = 1;
    busy_n   = 0;
    mode_bad = 0;
    chk({r.name, "_done_clr"}, 32'(done), 32'd0);
    chk({r.name, "_busy_on"}, 32'(busy), 32'd1);
    while (!done && edges < 20000) begin
      if (busy) busy_n++;
      if (busy && r.om && (bus.Mode != r.mv)) mode_bad++;
      @(negedge clk);
      edges++;
    end
    chk({r.name, "_done"}, 32'(done), 32'd1);
    chk({r.name, "_edges"}, 32'(edges), 32'(r.exp_edges));
    chk({r.name, "_busy_cycles"}, 32'(busy_n), 32'(r.exp_busy));
    chk({r.name, "_busy_off"}, 32'(busy), 32'd0);
    chk({r.name, "_pass"}, 32'(pass), 32'(r.exp_pass));
    chk({r.name, "_fail_vec"}, 32'(fail_vec), 32'(r.exp_fv));
    chk({r.name, "_fail_a"}, 32'(fail_a), 32'(r.exp_fa));
    chk({r.name, "_fail_b"}, 32'(fail_b), 32'(r.exp_fb));
    if (r.om) chk({r.name, "_mode_held"}, 32'(mode_bad), 32'd0);
    repeat (3) @(negedge clk);
    chk({r.name, "_stim_hold"}, 32'(vec_c), 32'(r.exp_hold));
    chk({r.name, "_done_sticky"}, 32'(done), 32'd1);
  endtask

  initial begin
    tbl[0] = '{"full_pass",  1'b0, 1'b0, 8'h00, 1'b0, 14'h0000, 1'b0, 16387, 16386, 1'b1, 14'h0000, 2'b00, 2'b00, 14'h3FFF};
    tbl[1] = '{"one_mode_c0", 1'b0, 1'b1, 8'hC0, 1'b0, 14'h0000, 1'b0, 67,    66,    1'b1, 14'h0000, 2'b00, 2'b00, 14'h303F};
    tbl[2] = '{"inj_2a5b",   1'b0, 1'b0, 8'h00, 1'b1, 14'h2A5B, 1'b0, 10847, 10846, 1'b0, 14'h2A5B, 2'b11, 2'b10, 14'h2A5D};
    tbl[3] = '{"inj_last",   1'b0, 1'b0, 8'h00, 1'b1, 14'h3FFF, 1'b0, 16387, 16386, 1'b0, 14'h3FFF, 2'b11, 2'b10, 14'h3FFF};
    tbl[4] = '{"lat_off",    1'b1, 1'b1, 8'hAA, 1'b0, 14'h0000, 1'b1, 5,     4,     1'b0, 14'h2A81, 2'b01, 2'b00, 14'h2A83};

    rst      = 1'b1;
    start    = 1'b0;
    one_mode = 1'b0;
    mode_val = 8'h00;
    inj_en   = 1'b0;
    inj_vec  = '0;
    b_slow   = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_stim", 32'(vec_c), 32'd0);
    chk("rst_fail_vec", 32'(fail_vec), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) run_one(tbl[i]);

    // Mid-run: a second start is ignored, then reset clears everything at once.
    do_reset();
    inj_en = 1'b0;
    b_slow = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("midrun_vec", 32'(vec_c), 32'h31);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_vec", 32'(vec_c), 32'h32);
    chk("ignored_start_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_stim", 32'(vec_c), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
